// File: rtl/target_readout.sv
// -----------------------------------------------------------------------------
// target_readout
//
// Arms and reads out the bank of per-microphone shot counters.
//   * On `arm` (only while idle) pulses `clear` for one cycle, then raises
//     `quiet` to let the counters run.
//   * Waits for the first channel to start, then for all channels to stop or
//     for TIMEOUT cycles to elapse, whichever comes first.
//   * Freezes for one cycle, snapshots every 16-bit count plus the per-channel
//     stopped mask, and streams a framed packet over valid/ready:
//       A5, {7'b0,to_flag}, stop_mask, ch0 MSB, ch0 LSB, ... chN-1 LSB
//
// Parameters
//   NCH      number of counter channels (1..8)
//   TIMEOUT  max cycles from first channel start to forced snapshot (>= 2)
//   TO_W     timeout timer width, must hold TIMEOUT
//
// Ports
//   clk        system clock
//   clr        asynchronous active-high reset
//   arm        single-cycle shot start request (ignored unless idle)
//   abort      drop back to idle from ARMED/WAIT without sending a frame
//   run        per-channel run flags from the counters
//   count      channel i count at bits [16i+15:16i]
//   clear      one-cycle clear pulse to all counters
//   quiet      count enable to all counters
//   busy       high in every state except IDLE
//   out_data   packet byte
//   out_valid  out_data is valid
//   out_last   high with the final packet byte
//   out_ready  consumer accepts the byte when out_valid & out_ready
// -----------------------------------------------------------------------------
module target_readout #(
    parameter int          NCH     = 8,
    parameter int unsigned TIMEOUT = 16'd50000,
    parameter int          TO_W    = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              arm,
    input  logic              abort,
    input  logic [NCH-1:0]    run,
    input  logic [16*NCH-1:0] count,
    output logic              clear,
    output logic              quiet,
    output logic              busy,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int NBYTES = 3 + 2 * NCH;
    localparam int IW     = $clog2(NBYTES);

    localparam logic [IW-1:0]   LAST_IDX = IW'(NBYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARMED,
        S_WAIT,
        S_FREEZE,
        S_SEND
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [TO_W-1:0] r_timer;
    logic [IW-1:0]   r_index;
    logic            r_to_flag;
    logic [NCH-1:0]  r_stop_mask;

    logic                  w_any_run;
    logic                  w_timer_hit;
    logic                  w_accept;
    logic                  w_last_byte;
    logic [7:0]            w_mask8;
    logic [NBYTES-1:0][7:0] w_bytes;

    assign w_any_run   = |run;
    assign w_timer_hit = (r_timer == TO_LAST);
    assign w_last_byte = (r_index == LAST_IDX);
    // Decoded from the state rather than out_valid so the next-state logic
    // does not read back one of its own outputs.
    assign w_accept    = (r_state == S_SEND) && out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        clear        = 1'b0;
        quiet        = 1'b0;
        busy         = 1'b1;
        out_valid    = 1'b0;
        out_last     = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (arm) begin
                    w_state_next = S_CLEAR;
                end
            end

            S_CLEAR: begin
                clear        = 1'b1;
                w_state_next = S_ARMED;
            end

            S_ARMED: begin
                quiet = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_any_run) begin
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                quiet = 1'b1;
                // Abort beats both exits; a stop in the same cycle as the
                // timeout is reported as a normal stop.
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (!w_any_run || w_timer_hit) begin
                    w_state_next = S_FREEZE;
                end
            end

            S_FREEZE: begin
                w_state_next = S_SEND;
            end

            S_SEND: begin
                out_valid = 1'b1;
                out_last  = w_last_byte;
                if (w_accept && w_last_byte) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Timer, timeout flag, stop mask and byte index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_timer     <= '0;
            r_index     <= '0;
            r_to_flag   <= 1'b0;
            r_stop_mask <= '0;
        end else begin
            case (r_state)
                S_ARMED: begin
                    // Holding zero here means the timer reads 0 in the first
                    // WAIT cycle whichever edge the start is detected on.
                    r_timer <= '0;
                end

                S_WAIT: begin
                    if (!abort) begin
                        if (!w_any_run) begin
                            r_to_flag <= 1'b0;
                        end else if (w_timer_hit) begin
                            r_to_flag <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TO_W'(1);
                        end
                    end
                end

                S_FREEZE: begin
                    r_stop_mask <= ~run;
                    r_index     <= '0;
                end

                S_SEND: begin
                    if (w_accept) begin
                        r_index <= w_last_byte ? '0 : r_index + IW'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Shadow count registers and packet byte map
    // -------------------------------------------------------------------------
    // Shadows load only on the FREEZE exit edge, so they hold still for the
    // whole SEND phase regardless of what the counters do.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [15:0] r_shadow;

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_shadow <= '0;
                end else if (r_state == S_FREEZE) begin
                    r_shadow <= count[16*gi +: 16];
                end
            end

            assign w_bytes[3 + 2*gi] = r_shadow[15:8];
            assign w_bytes[4 + 2*gi] = r_shadow[7:0];
        end
    endgenerate

    always_comb begin
        w_mask8            = '0;
        w_mask8[NCH-1:0]   = r_stop_mask;
    end

    assign w_bytes[0] = 8'hA5;
    assign w_bytes[1] = {7'b0, r_to_flag};
    assign w_bytes[2] = w_mask8;

    // Forced to zero outside SEND so the bus reads 0 out of reset.
    assign out_data = (r_state == S_SEND) ? w_bytes[r_index] : 8'h00;

endmodule

// File: tb/tb_target_readout.sv
// -----------------------------------------------------------------------------
// tb_target_readout
//
// Drives shot scenarios into target_readout (NCH=8, TIMEOUT=1000). Each shot
// is described by per-channel run intervals and count bases, counted in clock
// edges from the edge that samples `arm` (edge 0). A reference model derives
// start edge, stop/timeout edge, capture edge and the whole packet from those
// intervals; the bench then checks every cycle's control outputs and every
// transferred byte. A table holds the directed scenarios; random shots follow.
// -----------------------------------------------------------------------------
module tb_target_readout;

    localparam int NCH     = 8;
    localparam int TIMEOUT = 1000;
    localparam int NBYTES  = 3 + 2 * NCH;
    localparam int BUDGET  = 3000;
    localparam int NTBL    = 11;
    localparam int NRAND   = 6;

    logic              clk = 1'b0;
    logic              clr;
    logic              arm;
    logic              abort;
    logic [NCH-1:0]    run;
    logic [16*NCH-1:0] count;
    logic              clear;
    logic              quiet;
    logic              busy;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    always #5 clk = ~clk;

    target_readout #(
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT),
        .TO_W    (16)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .arm       (arm),
        .abort     (abort),
        .run       (run),
        .count     (count),
        .clear     (clear),
        .quiet     (quiet),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // rise/fall: run[i] is sampled high on edges rise <= k < fall
    // (rise 0 = channel never runs, fall 0 = never stops).
    // abort_k/arm2_k/arm3_k: edge on which that input is sampled high (0 = none).
    // clr_at: assert clr while this byte index is presented (0 = none).
    typedef struct packed {
        logic [NCH-1:0][15:0] rise;
        logic [NCH-1:0][15:0] fall;
        logic [NCH-1:0][15:0] base;
        logic [15:0]          abort_k;
        logic [15:0]          arm2_k;
        logic [15:0]          arm3_k;
        logic [15:0]          clr_at;
        logic                 arm_end;
        logic                 ready_rand;
        logic                 check_exp;
        logic                 exp_to;
        logic [7:0]           exp_mask;
    } shot_t;

    int    checks = 0;
    int    errors = 0;
    int    cur_shot = 0;
    shot_t tbl [NTBL];

    // Reference model results
    int         m_u;
    int         m_v;
    int         m_c;
    bit         m_to;
    bit         m_abort;
    logic [7:0] m_bytes [NBYTES];

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s shot=%0d cycle=%0d got=%0h expected=%0h", name, cur_shot, j, act, exp);
        end
    endtask

    function automatic bit run_at(input shot_t s, input int i, input int k);
        int r;
        int f;
        r = int'(s.rise[i]);
        f = int'(s.fall[i]);
        if (r == 0) return 1'b0;
        return (k >= r) && (f == 0 || k < f);
    endfunction

    // Counter grows by one per edge while running, holds after, saturates.
    function automatic logic [15:0] count_at(input shot_t s, input int i, input int k);
        int r;
        int f;
        int e;
        int n;
        int val;
        r = int'(s.rise[i]);
        f = int'(s.fall[i]);
        if (r == 0) return s.base[i];
        e = (f != 0 && f < k) ? f : k;
        n = e - r;
        if (n < 0) n = 0;
        val = int'(s.base[i]) + n;
        if (val > 65535) val = 65535;
        return 16'(val);
    endfunction

    function automatic bit all_low(input shot_t s, input int k);
        bit lo;
        lo = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (run_at(s, i, k)) lo = 1'b0;
        end
        return lo;
    endfunction

    task automatic build_model(input shot_t s);
        bit         found;
        logic [7:0] mask;
        logic [15:0] c16;
        // Start: first edge the controller is ARMED (edge 2 onward) with a run bit up.
        m_u = -1;
        for (int k = 2; k < 4000; k++) begin
            if (m_u < 0 && !all_low(s, k)) m_u = k;
        end
        // Stop: first edge after the start with every run bit low, else timeout.
        found = 1'b0;
        m_v   = m_u + TIMEOUT;
        for (int k = m_u + 1; k <= m_u + TIMEOUT; k++) begin
            if (!found && all_low(s, k)) begin
                found = 1'b1;
                m_v   = k;
            end
        end
        m_to    = !found;
        m_c     = m_v + 1;
        m_abort = (s.abort_k != 0) && (int'(s.abort_k) >= 2) && (int'(s.abort_k) <= m_v);
        mask = '0;
        for (int i = 0; i < NCH; i++) mask[i] = !run_at(s, i, m_c);
        m_bytes[0] = 8'hA5;
        m_bytes[1] = {7'b0, m_to};
        m_bytes[2] = mask;
        for (int i = 0; i < NCH; i++) begin
            c16 = count_at(s, i, m_c);
            m_bytes[3 + 2*i] = c16[15:8];
            m_bytes[4 + 2*i] = c16[7:0];
        end
    endtask

    task automatic drive_chan(input shot_t s, input int k);
        for (int i = 0; i < NCH; i++) begin
            run[i]            = run_at(s, i, k);
            count[16*i +: 16] = count_at(s, i, k);
        end
    endtask

    // Called right after a falling edge; the next rising edge is edge 0.
    task automatic do_shot(input shot_t s);
        int         nb;
        int         done_e;
        int         kill_j;
        int         stall_left;
        int         j;
        int         k;
        bit         ended;
        bit         idle_exp;
        bit         prev_stall;
        bit         rdy;
        logic [7:0] prev_data;

        build_model(s);
        nb = 0; done_e = -1; kill_j = -1; stall_left = 0;
        ended = 1'b0; prev_stall = 1'b0; prev_data = '0;

        arm = 1'b1; abort = 1'b0; out_ready = 1'b1;
        drive_chan(s, 0);

        for (j = 0; j < BUDGET && !ended; j++) begin
            @(negedge clk);
            idle_exp = (m_abort && j >= int'(s.abort_k)) || (kill_j >= 0 && j >= kill_j)
                       || (done_e >= 0 && j >= done_e);
            chk("clear",     j, 32'(clear),     32'(!idle_exp && j == 0));
            chk("busy",      j, 32'(busy),      32'(!idle_exp));
            chk("quiet",     j, 32'(quiet),     32'(!idle_exp && j >= 1 && j < m_v));
            chk("out_valid", j, 32'(out_valid), 32'(!idle_exp && j >= m_c));
            if (prev_stall) chk("stall_data", j, 32'(out_data), 32'(prev_data));

            if ((m_abort && j >= int'(s.abort_k) + 3) || (kill_j >= 0 && j >= kill_j + 2)
                || (done_e >= 0 && j >= done_e + 1)) begin
                ended = 1'b1;
            end else begin
                k = j + 1;
                arm   = (s.arm2_k != 0 && k == int'(s.arm2_k)) || (s.arm3_k != 0 && k == int'(s.arm3_k));
                abort = (s.abort_k != 0 && k == int'(s.abort_k));
                drive_chan(s, k);

                if (!s.ready_rand) begin
                    rdy = 1'b1;
                end else if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if ($urandom_range(0, 7) == 0) begin
                    rdy = 1'b0;
                    stall_left = 9;
                end else begin
                    rdy = ($urandom_range(0, 1) == 1);
                end
                out_ready = rdy;

                if (out_valid && !idle_exp && s.clr_at != 0 && nb == int'(s.clr_at)) begin
                    clr = 1'b1;
                    #1;
                    chk("clr_clear",     j, 32'(clear),     32'(0));
                    chk("clr_quiet",     j, 32'(quiet),     32'(0));
                    chk("clr_busy",      j, 32'(busy),      32'(0));
                    chk("clr_out_valid", j, 32'(out_valid), 32'(0));
                    chk("clr_out_last",  j, 32'(out_last),  32'(0));
                    chk("clr_out_data",  j, 32'(out_data),  32'(0));
                    #1;
                    clr    = 1'b0;
                    kill_j = j + 1;
                    rdy    = 1'b0;
                end else if (out_valid && rdy && !idle_exp && nb < NBYTES) begin
                    chk("byte",     j, 32'(out_data), 32'(m_bytes[nb]));
                    chk("out_last", j, 32'(out_last), 32'(nb == NBYTES - 1));
                    if (s.check_exp && nb == 1) chk("tbl_to",   j, 32'(out_data), 32'({7'b0, s.exp_to}));
                    if (s.check_exp && nb == 2) chk("tbl_mask", j, 32'(out_data), 32'(s.exp_mask));
                    nb++;
                    if (nb == NBYTES) begin
                        done_e = k;
                        if (s.arm_end) arm = 1'b1;
                    end
                end
                prev_stall = out_valid && !rdy && kill_j < 0;
                prev_data  = out_data;
            end
        end

        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL shot_budget shot=%0d got=%0d cycles expected=end of shot", cur_shot, j);
        end
        arm = 1'b0; abort = 1'b0; run = '0; out_ready = 1'b1;
    endtask

    function automatic shot_t basic_shot();
        shot_t s;
        s = '0;
        for (int i = 0; i < NCH; i++) begin
            s.rise[i] = 16'd5;
            s.fall[i] = 16'(15 + i);
            s.base[i] = 16'(257 * i + 7);
        end
        s.base[2]   = 16'hFFF8;   // saturates while running
        s.base[5]   = 16'hFFFF;   // already saturated
        s.check_exp = 1'b1;
        s.exp_to    = 1'b0;
        s.exp_mask  = 8'hFF;
        return s;
    endfunction

    function automatic shot_t slow_shot(input int last_fall);
        shot_t s;
        s = '0;
        for (int i = 0; i < NCH; i++) begin
            s.rise[i] = 16'd3;
            s.fall[i] = 16'(30 + i);
            s.base[i] = 16'(4000 * i);
        end
        s.fall[7]   = 16'(last_fall);
        s.check_exp = 1'b1;
        return s;
    endfunction

    initial begin
        shot_t s;

        clr = 1'b1; arm = 1'b0; abort = 1'b0; run = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_clear",     0, 32'(clear),     32'(0));
        chk("rst_quiet",     0, 32'(quiet),     32'(0));
        chk("rst_busy",      0, 32'(busy),      32'(0));
        chk("rst_out_valid", 0, 32'(out_valid), 32'(0));
        chk("rst_out_last",  0, 32'(out_last),  32'(0));
        chk("rst_out_data",  0, 32'(out_data),  32'(0));
        clr = 1'b0;
        @(negedge clk);

        // 0: basic shot
        tbl[0] = basic_shot();
        // 1: timeout, channel 3 never stops
        s = slow_shot(20);
        s.fall[3] = 16'd0;
        s.exp_to = 1'b1; s.exp_mask = 8'hF7;
        tbl[1] = s;
        // 2: last channel drops on exactly the timeout edge -> stop wins
        s = slow_shot(3 + TIMEOUT);
        s.exp_to = 1'b0; s.exp_mask = 8'hFF;
        tbl[2] = s;
        // 3: drops one edge too late -> timeout, but stopped by capture
        s = slow_shot(4 + TIMEOUT);
        s.exp_to = 1'b1; s.exp_mask = 8'hFF;
        tbl[3] = s;
        // 4: back-pressure
        s = basic_shot();
        s.ready_rand = 1'b1;
        tbl[4] = s;
        // 5: abort in ARMED
        s = basic_shot();
        for (int i = 0; i < NCH; i++) s.rise[i] = 16'd8;
        s.abort_k = 16'd4;
        tbl[5] = s;
        // 6: abort in WAIT
        s = '0;
        s.rise[0] = 16'd3;
        s.abort_k = 16'd50;
        tbl[6] = s;
        // 7: abort during SEND is ignored
        s = basic_shot();
        s.abort_k = 16'd27;
        tbl[7] = s;
        // 8: arm in WAIT, in SEND and on the final accept edge
        s = basic_shot();
        s.arm2_k = 16'd10; s.arm3_k = 16'd25; s.arm_end = 1'b1;
        tbl[8] = s;
        // 9: clr while byte 7 is presented
        s = basic_shot();
        s.clr_at = 16'd7;
        tbl[9] = s;
        // 10: single channel, run raised during CLEAR
        s = '0;
        s.rise[0] = 16'd1; s.fall[0] = 16'd9; s.base[0] = 16'h1234;
        s.check_exp = 1'b1; s.exp_to = 1'b0; s.exp_mask = 8'hFF;
        tbl[10] = s;

        for (int t = 0; t < NTBL; t++) begin
            cur_shot = t;
            do_shot(tbl[t]);
        end

        for (int t = 0; t < NRAND; t++) begin
            s = '0;
            for (int i = 0; i < NCH; i++) begin
                if (i == 0 || $urandom_range(0, 3) != 0) s.rise[i] = 16'($urandom_range(1, 30));
                if (s.rise[i] != 0 && $urandom_range(0, 4) != 0)
                    s.fall[i] = 16'(int'(s.rise[i]) + int'($urandom_range(1, 1100)));
                s.base[i] = 16'($urandom);
            end
            s.ready_rand = ($urandom_range(0, 1) == 1);
            cur_shot = NTBL + t;
            do_shot(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog shot=%0d got=no finish expected=finish", cur_shot);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/target_readout.md
# target_readout

Readout and arming controller for the bank of per-microphone shot counters. It clears and arms the counters, and gates their counting with `quiet`. It then waits for the shot to finish (all channels stopped, or timeout), snapshots every 16-bit count and streams a framed byte packet to the host-side interface over a valid/ready handshake. It sits between the counter bank and the host serial/bus bridge.

## Interface
- `NCH`, 8: number of counter channels (1..8).
- `TIMEOUT`, 16'd50000: max clk cycles from first channel start to forced snapshot (≥2).
- `TO_W`, 16: width of the timeout timer; must hold `TIMEOUT`.

- `clk` in 1: system clock.
- `clr` in 1: reset clr, asynchronous, active-high; clock clk.
- `arm` in 1: single-cycle request to start a shot cycle; ignored unless idle.
- `abort` in 1: return to idle from ARMED/WAIT without sending a frame.
- `run` in NCH: per-channel run flags from the counters.
- `count` in 16*NCH: channel i count at bits [16i+15:16i].
- `clear` out 1: one-cycle clear pulse to all counters.
- `quiet` out 1: count enable to all counters.
- `busy` out 1: high in every state except IDLE.
- `out_data` out 8: packet byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: high with the final byte of the packet.
- `out_ready` in 1: consumer accepts the byte when `out_valid & out_ready`.

## Operation
- States: IDLE, CLEAR, ARMED, WAIT, FREEZE, SEND.
- IDLE: `arm` → CLEAR.
- CLEAR: lasts one cycle, then goes to ARMED.
- ARMED: `abort` → IDLE. Otherwise, if any `run` bit is high → WAIT, with the timer set to 0.
- WAIT: `abort` → IDLE. If all `run` bits are low → FREEZE with `to_flag`=0. Else if timer == TIMEOUT-1 → FREEZE with `to_flag`=1. Otherwise timer +1.
- `abort` has priority over the exit conditions in ARMED and WAIT.
- FREEZE: lasts one cycle. On its exit edge, latch all counts into the shadow registers, latch `stop_mask[i]` = ~run[i], and set byte index 0 → SEND.
- SEND: present bytes in order. Advance the index on each accepted byte. After the last byte is accepted → IDLE.
- Packet is 3+2*NCH bytes:
  - byte 0 = 8'hA5.
  - byte 1 = {7'b0, to_flag}.
  - byte 2 = stop_mask zero-extended to 8 bits.
  - then channel 0..NCH-1, each MSB byte then LSB byte.
- Moore outputs:
  - `clear` = (state==CLEAR).
  - `quiet` = (state==ARMED or WAIT).
  - `out_valid` = (state==SEND).
  - `out_last` = SEND and index==2+2*NCH.
- `out_data` is muxed from the shadow registers by the index. It is stable while `out_valid & ~out_ready`.
- The shadow registers are not modified while in SEND. Counter changes during SEND do not affect the packet.
- `abort` in IDLE, CLEAR, FREEZE or SEND is ignored. A started packet always completes.
- Reset values: state IDLE, `clear` 0, `quiet` 0, `busy` 0, `out_valid` 0, `out_last` 0, `out_data` 0, timer 0, index 0, shadows 0, `to_flag` 0.

## Timing
- `arm` high at edge t:
  - `clear` is high for cycle t+1 only.
  - `quiet` rises at t+2.
  - `busy` rises at t+1.
- Start detection: if `run` goes high before edge u, WAIT is entered at u. Timer = 0 in the first WAIT cycle.
- Normal stop:
  - All `run` bits low sampled at edge v (in WAIT) → FREEZE during v..v+1, with `quiet` low from v.
  - Counts are captured at v+1.
  - First byte is valid at v+1.
- Timeout: if the timer reaches TIMEOUT-1, the snapshot follows TIMEOUT cycles after entering WAIT. Channels still running report their frozen count with mask bit 0.
- Simultaneous all-stopped and timeout in the same cycle: the stop wins, `to_flag`=0.
- Throughput: with `out_ready` held high, one byte per cycle, and the packet takes 3+2*NCH cycles. IDLE is entered on the edge after the last byte is accepted.
- `arm` on that same edge is ignored. `arm` is accepted the cycle after.
- `clr` asserted mid-packet: immediate return to reset values; no partial frame resumes.
- Counts at 16'hFFFF (counter saturated) are reported unchanged.

## Test plan
- Basic shot (NCH=8, TIMEOUT=1000):
  - Stimulus: arm; raise all `run` 5 cycles later; drop `run[i]` at 10+i cycles, with counts modelled.
  - Response: 19-byte packet A5, 00, FF, then each count MSB/LSB; `out_last` on byte 18 only; `clear` exactly one cycle.
- Timeout:
  - Stimulus: `run[3]` held high past 1000 cycles.
  - Response: byte1=01, byte2=F7, FREEZE entered exactly 1000 cycles after WAIT entry.
- Back-pressure:
  - Stimulus: toggle `out_ready` randomly, including 10-cycle stalls.
  - Response: byte sequence identical to the no-stall case; `out_data` constant while stalled.
- Abort:
  - Stimulus: abort in ARMED, and separately abort in WAIT.
  - Response: IDLE next cycle, `quiet` low, no `out_valid`. Abort during SEND: packet completes.
- Arm while busy / reset:
  - Stimulus: pulse `arm` in WAIT and SEND.
  - Response: no second `clear` pulse.
  - Stimulus: `clr` in SEND at byte 7.
  - Response: all outputs return to reset values the same cycle.
- Stop/timeout coincidence:
  - Stimulus: last `run` drops exactly at timer = TIMEOUT-1.
  - Response: byte1=00, byte2=FF.
